encoder4_2_serializer: RTL and testbench
========================================

# encoder4_2_serializer

Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 decoder. It captures a 4-bit request vector and emits the 2-bit index {A,B} of every asserted bit, one per accepted valid/ready handshake, in fixed priority order. Its encoding matches the decoder exactly (Y0=00, Y1=01, Y2=10, Y3=11), so {A,B} can drive a decoder directly to reproduce each request one-hot. It sits between request sources and any downstream decoder or address consumer.

## Interface
Parameters:
- LSB_FIRST, default 1: 1 means service order Y0→Y3 (lowest index first); 0 means Y3→Y0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  block enable; low flushes pending work (see Operation).
- load  input  1  capture strobe for D.
- D  input  4  request vector; D[i] corresponds to decoder output Yi.
- ready  input  1  downstream accepts the current index.
- A  output  1  index MSB, registered.
- B  output  1  index LSB, registered.
- valid  output  1  {A,B} holds a valid index, registered.
- busy  output  1  high while in SERVE; load is ignored when high.
- none  output  1  one-cycle pulse when a load captured D==0.

## Operation
- States: IDLE, SERVE. Internal 4-bit pending register.
- Reset: state=IDLE; pending=0; A=0, B=0, valid=0, none=0; busy=0.
- IDLE, enable=1, load=1, D≠0:
  - pending←D.
  - {A,B}←index of the highest-priority bit of D; valid←1.
  - Next state SERVE.
- IDLE, enable=1, load=1, D==0: none←1 for exactly one cycle; stay in IDLE; valid stays 0.
- IDLE, enable=0: load is ignored; no state change.
- SERVE, enable=1, valid&ready:
  - Clear the pending bit for the current index.
  - If other bits remain: {A,B}←next priority index; valid stays 1.
  - If none remain: valid←0; {A,B}←00; next state IDLE.
- SERVE, ready=0: A, B and valid hold stable. Stability is required while valid=1 and ready=0.
- SERVE, enable=0: pending←0, valid←0, {A,B}←00, next state IDLE. Flush takes priority over a same-cycle handshake; that index counts as not delivered.
- load in SERVE: ignored, including the cycle of the final handshake. A new load is accepted only on a cycle where busy=0.
- D is sampled only on the accepting load edge. Later D changes do not affect pending.
- rst overrides everything on the same edge, including mid-SERVE; outputs return to reset values.

## Timing
- Load-to-valid latency: load sampled at edge k → valid=1 with the first index during cycle k+1.
- Throughput: one index per cycle while ready is held high. N set bits in D give N consecutive valid cycles.
- Last handshake at edge m → valid=0 and busy=0 in cycle m+1. The earliest new load is accepted at edge m+1.
- none is asserted in the cycle after the load edge, for one cycle only.
- Combinational paths from inputs to outputs: none. All outputs come from flops (busy is decoded from the state flop).

## Structure
- Package encoder_pkg:
  - state enum {IDLE, SERVE};
  - IDX_W=2, REQ_W=4 constants;
  - Yi↔index mapping constants shared with the decoder.
- Sub-module prio_enc4: purely combinational.
  - Inputs: pending[3:0] and LSB_FIRST.
  - Outputs: idx[1:0] and any.
  - Instantiated once. It feeds both the load path (on D) and the advance path (on pending with the current bit masked).
- The top level holds the FSM, the pending register and the output registers.

## Test plan
- Reset then load D=1010, LSB_FIRST=1, ready=1 → {A,B}=01 then 11 in consecutive cycles; then valid=0 and busy=0.
- D=1111, LSB_FIRST=0, ready toggling 1,0,1,1,1 → indices 11,(hold 10),10,01,00; {A,B} stable during the ready=0 cycle.
- load with D=0000 in IDLE → none pulses one cycle; valid stays 0; busy stays 0.
- In SERVE with D=0111, pulse load with D=1000 → ignored; only 00,01,10 are emitted.
- enable dropped after the first handshake of D=1100 → valid=0 next cycle and state IDLE; index 11 is never emitted.
- rst asserted mid-SERVE → next cycle A=B=valid=busy=none=0; a following load of D=0001 yields {A,B}=00.

Source files
------------

// File: rtl/encoder4_2_serializer_pkg.sv
// Shared types and constants for the 4-to-2 serializing encoder and its
// companion 2-to-4 decoder.
package encoder_pkg;

    localparam int IDX_W = 2;
    localparam int REQ_W = 4;

    // Request bit Yi <-> index {A,B}, identical to the decoder mapping
    localparam logic [IDX_W-1:0] IDX_Y0 = 2'b00;
    localparam logic [IDX_W-1:0] IDX_Y1 = 2'b01;
    localparam logic [IDX_W-1:0] IDX_Y2 = 2'b10;
    localparam logic [IDX_W-1:0] IDX_Y3 = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    // One-hot request bit selected by an index (what the decoder would drive)
    function automatic logic [REQ_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [REQ_W-1:0] oh;
        oh = '0;
        case (idx)
            IDX_Y0:  oh = 4'b0001;
            IDX_Y1:  oh = 4'b0010;
            IDX_Y2:  oh = 4'b0100;
            IDX_Y3:  oh = 4'b1000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/encoder4_2_serializer_if.sv
// Request/index bus of the serializing encoder. The request source is the
// master; the encoder is the slave.
interface encoder4_2_serializer_if;
    import encoder_pkg::*;

    logic             enable;
    logic             load;
    logic [REQ_W-1:0] D;
    logic             ready;
    logic             A;
    logic             B;
    logic             valid;
    logic             busy;
    logic             none;

    modport master (
        output enable, load, D, ready,
        input  A, B, valid, busy, none
    );

    modport slave (
        input  enable, load, D, ready,
        output A, B, valid, busy, none
    );

endinterface

// File: rtl/encoder4_2_serializer_prio_enc4.sv
// Combinational 4-input priority encoder; direction chosen by LSB_FIRST.
module prio_enc4
    import encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [REQ_W-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Later matches overwrite earlier ones, so scan toward the winning end
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        if (LSB_FIRST) begin
            for (int unsigned i = 0; i < REQ_W; i++) begin
                if (req_i[REQ_W-1-i]) idx_o = IDX_W'(REQ_W-1-i);
            end
        end else begin
            for (int unsigned i = 0; i < REQ_W; i++) begin
                if (req_i[i]) idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder4_2_serializer.sv
// Sequential 4-to-2 encoder: captures a request vector and emits the index
// of each set bit, one per valid/ready handshake, in priority order.
module encoder4_2_serializer
    import encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    encoder4_2_serializer_if.slave   bus
);

    state_e           state_q, state_d;
    logic [REQ_W-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             none_q, none_d;

    logic [REQ_W-1:0] enc_req;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    // One encoder serves both paths: the raw request in IDLE, and the
    // pending set minus the index being delivered in SERVE.
    always_comb begin
        if (state_q == IDLE) enc_req = bus.D;
        else                 enc_req = pending_q & ~idx_to_onehot(idx_q);
    end

    prio_enc4 #(
        .LSB_FIRST (LSB_FIRST)
    ) u_prio (
        .req_i (enc_req),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        none_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable && bus.load) begin
                    if (bus.D != '0) begin
                        pending_d = bus.D;
                        idx_d     = enc_idx;
                        valid_d   = 1'b1;
                        state_d   = SERVE;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                // Flush wins over a same-cycle handshake
                if (!bus.enable) begin
                    pending_d = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    state_d   = IDLE;
                end else if (valid_q && bus.ready) begin
                    pending_d = enc_req;
                    if (enc_any) begin
                        idx_d = enc_idx;
                    end else begin
                        idx_d   = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            none_q    <= none_d;
        end
    end

    assign bus.A     = idx_q[1];
    assign bus.B     = idx_q[0];
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q == SERVE);
    assign bus.none  = none_q;

endmodule

// File: tb/tb_encoder4_2_serializer.sv
// Directed bench for encoder4_2_serializer: one instance per service order,
// both driven by the same stimulus.
module tb_encoder4_2_serializer;
    import encoder_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    encoder4_2_serializer_if ifl ();
    encoder4_2_serializer_if ifm ();

    assign ifm.enable = ifl.enable;
    assign ifm.load   = ifl.load;
    assign ifm.D      = ifl.D;
    assign ifm.ready  = ifl.ready;

    encoder4_2_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (ifl.slave)
    );

    encoder4_2_serializer #(.LSB_FIRST(1'b0)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (ifm.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {A,B,valid,busy,none} of each instance
    function automatic logic [7:0] st_l();
        return {3'b000, ifl.A, ifl.B, ifl.valid, ifl.busy, ifl.none};
    endfunction

    function automatic logic [7:0] st_m();
        return {3'b000, ifm.A, ifm.B, ifm.valid, ifm.busy, ifm.none};
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        ifl.enable = 1'b0;
        ifl.load   = 1'b0;
        ifl.D      = '0;
        ifl.ready  = 1'b0;
        tick();
        tick();
        check("reset_lsb", st_l(), 8'b00000);
        check("reset_msb", st_m(), 8'b00000);

        // D=1010, LSB first, ready held high
        rst        = 1'b0;
        ifl.enable = 1'b1;
        ifl.ready  = 1'b1;
        ifl.D      = 4'b1010;
        ifl.load   = 1'b1;
        tick();
        ifl.load   = 1'b0;
        ifl.D      = 4'b0000;
        check("t1_first",  st_l(), 8'b01110);
        check("t1_m_first", st_m(), 8'b11110);
        tick();
        check("t1_second", st_l(), 8'b11110);
        check("t1_m_second", st_m(), 8'b01110);
        tick();
        check("t1_done",   st_l(), 8'b00000);

        // D=1111, MSB first, ready 1,0,1,1,1
        ifl.D    = 4'b1111;
        ifl.load = 1'b1;
        tick();
        ifl.load = 1'b0;
        check("t2_idx3", st_m(), 8'b11110);
        tick();
        check("t2_idx2", st_m(), 8'b10110);
        ifl.ready = 1'b0;
        tick();
        check("t2_hold", st_m(), 8'b10110);
        ifl.ready = 1'b1;
        tick();
        check("t2_idx1", st_m(), 8'b01110);
        tick();
        check("t2_idx0", st_m(), 8'b00110);
        tick();
        check("t2_done", st_m(), 8'b00000);

        // Empty request
        ifl.D    = 4'b0000;
        ifl.load = 1'b1;
        tick();
        ifl.load = 1'b0;
        check("t3_none",  st_l(), 8'b00001);
        tick();
        check("t3_pulse", st_l(), 8'b00000);

        // load during SERVE is ignored
        ifl.D    = 4'b0111;
        ifl.load = 1'b1;
        tick();
        check("t4_idx0", st_l(), 8'b00110);
        ifl.D    = 4'b1000;
        ifl.load = 1'b1;
        tick();
        ifl.load = 1'b0;
        check("t4_idx1", st_l(), 8'b01110);
        tick();
        check("t4_idx2", st_l(), 8'b10110);
        tick();
        check("t4_done", st_l(), 8'b00000);
        tick();
        check("t4_stay", st_l(), 8'b00000);

        // Flush after first handshake of D=1100
        ifl.D    = 4'b1100;
        ifl.load = 1'b1;
        tick();
        ifl.load = 1'b0;
        check("t5_idx2", st_l(), 8'b10110);
        tick();
        check("t5_idx3", st_l(), 8'b11110);
        ifl.enable = 1'b0;
        tick();
        check("t5_flush", st_l(), 8'b00000);
        check("t5_m_flush", st_m(), 8'b00000);
        ifl.enable = 1'b1;
        tick();
        check("t5_after", st_l(), 8'b00000);

        // Reset in the middle of SERVE
        ifl.D    = 4'b0111;
        ifl.load = 1'b1;
        tick();
        ifl.load = 1'b0;
        tick();
        check("t6_pre", st_l(), 8'b01110);
        rst = 1'b1;
        tick();
        check("t6_rst",   st_l(), 8'b00000);
        check("t6_m_rst", st_m(), 8'b00000);
        rst      = 1'b0;
        ifl.D    = 4'b0001;
        ifl.load = 1'b1;
        tick();
        ifl.load = 1'b0;
        check("t6_reload", st_l(), 8'b00110);
        tick();
        check("t6_done", st_l(), 8'b00000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
